// File: rtl/traffic_pkg.sv
// traffic_pkg: FSM state type, counter widths and the test-pattern byte function for traffic_sink.
package traffic_pkg;
  typedef enum logic [1:0] {IDLE, RECV, DONE} state_e;
  localparam int PKT_CNT_W = 32;
  localparam int BYTE_CNT_W = 64;
  localparam int ERR_CNT_W = 16;
  localparam int LEN_W = 16;
  localparam int SEQ_W = 16;
  function automatic logic [7:0] pattern_byte(input logic [SEQ_W-1:0] seq, input logic [LEN_W-1:0] off);
    pattern_byte = 8'(seq + off);
  endfunction
endpackage

// File: rtl/traffic_pattern_chk.sv
// traffic_pattern_chk: checks every enabled byte against (seq + offset) mod 256 and flags a bad packet.
module traffic_pattern_chk
  import traffic_pkg::*;
#(
  parameter int TX_LEN = 512
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  input  logic                beat,
  input  logic                last,
  input  logic [TX_LEN-1:0]   data,
  input  logic [TX_LEN/8-1:0] ben,
  input  logic [LEN_W-1:0]    off,
  output logic                pkt_bad
);
  localparam int BW = TX_LEN / 8;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic bad_q, bad_d, mis;
  always_comb begin
    mis = 1'b0;
    for (int j = 0; j < BW; j++)
      mis = mis | (ben[j] && data[8*j +: 8] != pattern_byte(seq_q, off + LEN_W'(j)));
    pkt_bad = bad_q | (beat & mis);
    bad_d = beat ? (!last && pkt_bad) : bad_q;
    seq_d = (beat && last) ? seq_q + 1'b1 : seq_q;
  end
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      seq_q <= '0;
      bad_q <= 1'b0;
    end else begin
      seq_q <= seq_d;
      bad_q <= bad_d;
    end
  end
endmodule

// File: rtl/traffic_sink.sv
// traffic_sink: AXI-Stream packet sink with length/byte statistics and an optional
// data-pattern checker enabled by TRAFFIC_SINK_PATTERN_CHK_EN.
module traffic_sink
  import traffic_pkg::*;
#(
  parameter int TX_LEN        = 512,
  parameter int MAX_ETH_FRAME = 4096
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  input  logic [31:0]         control_reg,
  input  logic [15:0]         txr_size,
  input  logic [15:0]         num_pkt,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic [TX_LEN-1:0]   tx_data,
  input  logic [TX_LEN/8-1:0] tx_ben,
  input  logic                tx_last,
  output logic [31:0]         pkt_count,
  output logic [63:0]         byte_count,
  output logic [15:0]         len_err_count,
  output logic [15:0]         data_err_count,
  output logic                done
);
  localparam int BW = TX_LEN / 8;
  localparam int PW = $clog2(BW + 1);
  state_e state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic in_pkt_q, in_pkt_d, ben_err_q, ben_err_d, over_q, over_d;
  logic [PKT_CNT_W-1:0] pkt_q, pkt_d;
  logic [BYTE_CNT_W-1:0] bytes_q, bytes_d;
  logic [ERR_CNT_W-1:0] len_err_q, len_err_d, data_err_q, data_err_d;
  logic enable, clear, beat, eop, ben_bad, over_now, pkt_len_bad, pkt_data_bad, hit;
  logic [PW-1:0] pop;
  logic [LEN_W:0] len_sum;
  logic unused_ctrl;
  assign unused_ctrl = ^control_reg[31:2];
  assign enable = control_reg[1];
  assign clear = control_reg[0];
  assign tx_ready = state_q == RECV;
  assign done = state_q == DONE;
  assign pkt_count = pkt_q;
  assign byte_count = bytes_q;
  assign len_err_count = len_err_q;
  assign data_err_count = data_err_q;
`ifdef TRAFFIC_SINK_PATTERN_CHK_EN
  traffic_pattern_chk #(.TX_LEN(TX_LEN)) u_chk (
    .axi_aclk   (axi_aclk),
    .axi_aresetn(axi_aresetn),
    .beat       (beat),
    .last       (tx_last),
    .data       (tx_data),
    .ben        (tx_ben),
    .off        (len_q),
    .pkt_bad    (pkt_data_bad)
  );
`else
  logic unused_data;
  assign unused_data = ^tx_data;
  assign pkt_data_bad = 1'b0;
`endif
  always_comb begin
    pop = '0;
    for (int j = 0; j < BW; j++)
      pop = pop + PW'(tx_ben[j]);
    beat = tx_valid & tx_ready;
    eop = beat & tx_last;
    // last beat must be LSB-contiguous, every other beat fully enabled
    ben_bad = tx_last ? |(tx_ben & (tx_ben + 1'b1)) : ~&tx_ben;
    len_sum = {1'b0, len_q} + (LEN_W+1)'(pop);
    over_now = len_sum > (LEN_W+1)'(MAX_ETH_FRAME);
    pkt_len_bad = ben_err_q | ben_bad | over_q | over_now | (len_sum[LEN_W-1:0] != txr_size);
    in_pkt_d = beat ? !tx_last : in_pkt_q;
    len_d = beat ? (tx_last ? '0 : len_sum[LEN_W-1:0]) : len_q;
    ben_err_d = beat ? (!tx_last && (ben_err_q | ben_bad)) : ben_err_q;
    over_d = beat ? (!tx_last && (over_q | over_now)) : over_q;
    pkt_d = clear ? '0 : pkt_q + PKT_CNT_W'(eop);
    bytes_d = clear ? '0 : bytes_q + (beat ? BYTE_CNT_W'(pop) : '0);
    len_err_d = clear ? '0 : len_err_q + ERR_CNT_W'(eop && pkt_len_bad && !(&len_err_q));
    data_err_d = clear ? '0 : data_err_q + ERR_CNT_W'(eop && pkt_data_bad && !(&data_err_q));
    hit = num_pkt != '0 && pkt_d == PKT_CNT_W'(num_pkt);
    // an open packet always finishes before enable or the target is honoured
    state_d = state_q == IDLE ? (enable ? RECV : IDLE)
            : state_q == RECV ? (in_pkt_d ? RECV : !enable ? IDLE : hit ? DONE : RECV)
            : (clear || !enable) ? IDLE : DONE;
  end
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q <= IDLE;
      len_q <= '0;
      in_pkt_q <= 1'b0;
      ben_err_q <= 1'b0;
      over_q <= 1'b0;
      pkt_q <= '0;
      bytes_q <= '0;
      len_err_q <= '0;
      data_err_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      in_pkt_q <= in_pkt_d;
      ben_err_q <= ben_err_d;
      over_q <= over_d;
      pkt_q <= pkt_d;
      bytes_q <= bytes_d;
      len_err_q <= len_err_d;
      data_err_q <= data_err_d;
    end
  end
endmodule
